// File: rtl/scarv_cop_malu_arb_pkg.sv
// Shared definitions for the MALU arbiter: FSM encodings, watchdog default and
// the bundle of fields forwarded from the owning requester to the MALU.
package scarv_cop_malu_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int unsigned WDOG_LIMIT_DEFAULT = 4;

  typedef struct packed {
    logic [31:0] gpr_rs1;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rs3;
    logic [31:0] imm;
    logic [3:0]  cls;
    logic [4:0]  subcls;
  } malu_req_t;

endpackage

// File: rtl/scarv_cop_rr_arb2.sv
// Two-way round-robin picker: on contention the prio requester wins,
// otherwise whichever requester is valid wins.
module scarv_cop_rr_arb2
  import scarv_cop_malu_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       prio,
  output logic       winner,
  output logic       any
);

  // Select the winner among the valid requesters
  always_comb begin
    winner = 1'b0;
    any    = |valid;
    if (valid == 2'b11) begin
      winner = prio;
    end else if (valid[1]) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end

endmodule

// File: rtl/scarv_cop_malu_arb.sv
// Shares the single multi-precision ALU between CPU issue (req0) and the
// background sequencer (req1), holding the grant for a whole instruction.
module scarv_cop_malu_arb
  import scarv_cop_malu_arb_pkg::*;
#(
  parameter int unsigned WDOG_LIMIT = WDOG_LIMIT_DEFAULT
) (
  input  logic        g_clk,
  input  logic        g_resetn,

  input  logic        req0_valid,
  input  logic [31:0] req0_gpr_rs1,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  input  logic [31:0] req0_rs3,
  input  logic [31:0] req0_imm,
  input  logic [3:0]  req0_class,
  input  logic [4:0]  req0_subclass,
  output logic        req0_gnt,
  output logic        req0_done,
  output logic [3:0]  req0_rd_ben,
  output logic [31:0] req0_rd_wdata,
  output logic        req0_rdm_in_rs,

  input  logic        req1_valid,
  input  logic [31:0] req1_gpr_rs1,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  input  logic [31:0] req1_rs3,
  input  logic [31:0] req1_imm,
  input  logic [3:0]  req1_class,
  input  logic [4:0]  req1_subclass,
  output logic        req1_gnt,
  output logic        req1_done,
  output logic [3:0]  req1_rd_ben,
  output logic [31:0] req1_rd_wdata,
  output logic        req1_rdm_in_rs,

  output logic        malu_ivalid,
  output logic [31:0] malu_gpr_rs1,
  output logic [31:0] malu_rs1,
  output logic [31:0] malu_rs2,
  output logic [31:0] malu_rs3,
  output logic [31:0] malu_imm,
  output logic [3:0]  malu_class,
  output logic [4:0]  malu_subclass,
  input  logic        malu_idone,
  input  logic [3:0]  malu_rd_ben,
  input  logic [31:0] malu_rd_wdata,
  input  logic        malu_rdm_in_rs,

  output logic        err_wdog,
  output logic        err_proto
);

  localparam logic [2:0] WD_LAST = 3'(WDOG_LIMIT - 1);

  arb_state_t r_state;
  logic       r_owner;
  logic       r_prio;
  logic [2:0] r_wd;
  logic       r_err_wdog;
  logic       r_err_proto;

  logic       w_winner;
  logic       w_any;
  logic       w_busy;
  logic       w_own_valid;
  malu_req_t  w_req0;
  malu_req_t  w_req1;
  malu_req_t  w_own_req;

  assign w_req0 = {req0_gpr_rs1, req0_rs1, req0_rs2, req0_rs3, req0_imm,
                   req0_class, req0_subclass};
  assign w_req1 = {req1_gpr_rs1, req1_rs1, req1_rs2, req1_rs3, req1_imm,
                   req1_class, req1_subclass};

  assign w_busy = (r_state == ARB_BUSY);

  scarv_cop_rr_arb2 u_rr (
    .valid  ({req1_valid, req0_valid}),
    .prio   (r_prio),
    .winner (w_winner),
    .any    (w_any)
  );

  // Owner-side view of the request lines
  always_comb begin
    w_own_req   = '0;
    w_own_valid = 1'b0;
    if (r_owner) begin
      w_own_req   = w_req1;
      w_own_valid = req1_valid;
    end else begin
      w_own_req   = w_req0;
      w_own_valid = req0_valid;
    end
  end

  // Arbiter FSM, watchdog and sticky error flags
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_state     <= ARB_IDLE;
      r_owner     <= 1'b0;
      r_prio      <= 1'b0;
      r_wd        <= 3'd0;
      r_err_wdog  <= 1'b0;
      r_err_proto <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_wd <= 3'd0;
          if (w_any) begin
            r_owner <= w_winner;
            r_state <= ARB_BUSY;
          end else begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_BUSY: begin
          // Completion wins over a same-cycle valid drop: the owner may
          // release valid as soon as it sees its done pulse.
          if (malu_idone) begin
            r_state <= ARB_IDLE;
            r_prio  <= ~r_owner;
          end else if (!w_own_valid) begin
            r_err_proto <= 1'b1;
            r_state     <= ARB_IDLE;
          end else if (r_wd == WD_LAST) begin
            r_err_wdog <= 1'b1;
            r_state    <= ARB_IDLE;
          end else begin
            r_wd <= r_wd + 3'd1;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Operand mux to the MALU and writeback demux back to the owner
  always_comb begin
    malu_ivalid    = 1'b0;
    malu_gpr_rs1   = 32'd0;
    malu_rs1       = 32'd0;
    malu_rs2       = 32'd0;
    malu_rs3       = 32'd0;
    malu_imm       = 32'd0;
    malu_class     = 4'd0;
    malu_subclass  = 5'd0;
    req0_gnt       = 1'b0;
    req0_done      = 1'b0;
    req0_rd_ben    = 4'd0;
    req0_rd_wdata  = 32'd0;
    req0_rdm_in_rs = 1'b0;
    req1_gnt       = 1'b0;
    req1_done      = 1'b0;
    req1_rd_ben    = 4'd0;
    req1_rd_wdata  = 32'd0;
    req1_rdm_in_rs = 1'b0;
    if (w_busy) begin
      malu_ivalid   = w_own_valid;
      malu_gpr_rs1  = w_own_req.gpr_rs1;
      malu_rs1      = w_own_req.rs1;
      malu_rs2      = w_own_req.rs2;
      malu_rs3      = w_own_req.rs3;
      malu_imm      = w_own_req.imm;
      malu_class    = w_own_req.cls;
      malu_subclass = w_own_req.subcls;
      if (r_owner) begin
        req1_gnt       = 1'b1;
        req1_done      = malu_idone;
        req1_rd_ben    = malu_rd_ben;
        req1_rd_wdata  = malu_rd_wdata;
        req1_rdm_in_rs = malu_rdm_in_rs;
      end else begin
        req0_gnt       = 1'b1;
        req0_done      = malu_idone;
        req0_rd_ben    = malu_rd_ben;
        req0_rd_wdata  = malu_rd_wdata;
        req0_rdm_in_rs = malu_rdm_in_rs;
      end
    end else begin
      malu_ivalid = 1'b0;
    end
  end

  assign err_wdog  = r_err_wdog;
  assign err_proto = r_err_proto;

endmodule

// File: tb/tb_scarv_cop_malu_arb.sv
// Directed bench for the MALU arbiter; the MALU is mocked by driving its
// idone/writeback inputs straight from the scenario tasks.
module tb_scarv_cop_malu_arb;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_gpr_rs1, req0_rs1, req0_rs2, req0_rs3, req0_imm;
  logic [31:0] req1_gpr_rs1, req1_rs1, req1_rs2, req1_rs3, req1_imm;
  logic [3:0]  req0_class, req1_class;
  logic [4:0]  req0_subclass, req1_subclass;
  logic        req0_gnt, req0_done, req0_rdm_in_rs;
  logic        req1_gnt, req1_done, req1_rdm_in_rs;
  logic [3:0]  req0_rd_ben, req1_rd_ben;
  logic [31:0] req0_rd_wdata, req1_rd_wdata;
  logic        malu_ivalid;
  logic [31:0] malu_gpr_rs1, malu_rs1, malu_rs2, malu_rs3, malu_imm;
  logic [3:0]  malu_class;
  logic [4:0]  malu_subclass;
  logic        malu_idone, malu_rdm_in_rs;
  logic [3:0]  malu_rd_ben;
  logic [31:0] malu_rd_wdata;
  logic        err_wdog, err_proto;

  int errors = 0;
  int checks = 0;

  always #5 g_clk = ~g_clk;

  scarv_cop_malu_arb #(.WDOG_LIMIT(4)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req0_valid(req0_valid), .req0_gpr_rs1(req0_gpr_rs1), .req0_rs1(req0_rs1),
    .req0_rs2(req0_rs2), .req0_rs3(req0_rs3), .req0_imm(req0_imm),
    .req0_class(req0_class), .req0_subclass(req0_subclass),
    .req0_gnt(req0_gnt), .req0_done(req0_done), .req0_rd_ben(req0_rd_ben),
    .req0_rd_wdata(req0_rd_wdata), .req0_rdm_in_rs(req0_rdm_in_rs),
    .req1_valid(req1_valid), .req1_gpr_rs1(req1_gpr_rs1), .req1_rs1(req1_rs1),
    .req1_rs2(req1_rs2), .req1_rs3(req1_rs3), .req1_imm(req1_imm),
    .req1_class(req1_class), .req1_subclass(req1_subclass),
    .req1_gnt(req1_gnt), .req1_done(req1_done), .req1_rd_ben(req1_rd_ben),
    .req1_rd_wdata(req1_rd_wdata), .req1_rdm_in_rs(req1_rdm_in_rs),
    .malu_ivalid(malu_ivalid), .malu_gpr_rs1(malu_gpr_rs1), .malu_rs1(malu_rs1),
    .malu_rs2(malu_rs2), .malu_rs3(malu_rs3), .malu_imm(malu_imm),
    .malu_class(malu_class), .malu_subclass(malu_subclass),
    .malu_idone(malu_idone), .malu_rd_ben(malu_rd_ben),
    .malu_rd_wdata(malu_rd_wdata), .malu_rdm_in_rs(malu_rdm_in_rs),
    .err_wdog(err_wdog), .err_proto(err_proto)
  );

  // Advance to the next falling edge; inputs change here, checks follow #1
  task automatic cyc();
    @(negedge g_clk);
  endtask

  task automatic test_reset();
    g_resetn = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_gpr_rs1 = 32'd0; req0_rs1 = 32'd0; req0_rs2 = 32'd0; req0_rs3 = 32'd0; req0_imm = 32'd0;
    req1_gpr_rs1 = 32'd0; req1_rs1 = 32'd0; req1_rs2 = 32'd0; req1_rs3 = 32'd0; req1_imm = 32'd0;
    req0_class = 4'd0; req1_class = 4'd0; req0_subclass = 5'd0; req1_subclass = 5'd0;
    malu_idone = 1'b0; malu_rd_ben = 4'd0; malu_rd_wdata = 32'd0; malu_rdm_in_rs = 1'b0;
    repeat (3) cyc();
    #1;
    checks++;
    if ({req0_gnt, req1_gnt, req0_done, req1_done, malu_ivalid, err_wdog, err_proto} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {req0_gnt, req1_gnt, req0_done, req1_done, malu_ivalid, err_wdog, err_proto});
    end
    checks++;
    if ({malu_rs1, req0_rd_wdata, req1_rd_wdata} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {malu_rs1, req0_rd_wdata, req1_rd_wdata});
    end
    g_resetn = 1'b1;
  endtask

  task automatic test_single();
    cyc();
    req0_valid = 1'b1; req0_rs1 = 32'h0000_0005; req0_rs2 = 32'h0000_0003;
    req0_class = 4'h3; req0_subclass = 5'h02;
    #1;
    checks++;
    if (req0_gnt !== 1'b0) begin errors++; $display("FAIL single_idle_gnt: got %b expected 0", req0_gnt); end
    cyc(); #1;
    checks++;
    if ({req0_gnt, req1_gnt, malu_ivalid} !== 3'b101) begin
      errors++; $display("FAIL single_gnt: got %b expected 101", {req0_gnt, req1_gnt, malu_ivalid});
    end
    checks++;
    if ({malu_rs1, malu_rs2, malu_class, malu_subclass} !== {32'd5, 32'd3, 4'h3, 5'h02}) begin
      errors++; $display("FAIL single_operands: got %h %h %h %h expected 5 3 3 2",
                         malu_rs1, malu_rs2, malu_class, malu_subclass);
    end
    malu_rd_ben = 4'hF; malu_rd_wdata = 32'h0000_0008; malu_rdm_in_rs = 1'b1;
    #1;
    checks++;
    if ({req0_rd_ben, req0_rd_wdata, req0_rdm_in_rs, req0_done} !== {4'hF, 32'h8, 1'b1, 1'b0}) begin
      errors++; $display("FAIL single_wb_lo: got %h %h %b %b expected f 8 1 0",
                         req0_rd_ben, req0_rd_wdata, req0_rdm_in_rs, req0_done);
    end
    checks++;
    if ({req1_rd_ben, req1_rd_wdata, req1_rdm_in_rs} !== 37'd0) begin
      errors++; $display("FAIL single_nonowner_wb: got %h %h %b expected 0",
                         req1_rd_ben, req1_rd_wdata, req1_rdm_in_rs);
    end
    cyc();
    malu_rd_wdata = 32'h0000_0000; malu_rdm_in_rs = 1'b0; malu_idone = 1'b1; req0_valid = 1'b0;
    #1;
    checks++;
    if ({req0_done, req1_done, req1_gnt, req0_rd_wdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL single_done: got %b %b %b %h expected 1 0 0 0",
                         req0_done, req1_done, req1_gnt, req0_rd_wdata);
    end
    cyc();
    malu_idone = 1'b0; malu_rd_ben = 4'd0;
    #1;
    checks++;
    if ({req0_gnt, req1_gnt, err_proto, err_wdog} !== 4'b0000) begin
      errors++; $display("FAIL single_release: got %b expected 0000", {req0_gnt, req1_gnt, err_proto, err_wdog});
    end
  endtask

  task automatic test_back_to_back();
    logic exp;
    g_resetn = 1'b0;
    cyc();
    g_resetn = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 1);
      cyc(); #1;
      checks++;
      if ({req1_gnt, req0_gnt} !== {exp, ~exp}) begin
        errors++; $display("FAIL alt_gnt_%0d: got %b expected %b", k, {req1_gnt, req0_gnt}, {exp, ~exp});
      end
      malu_idone = 1'b1;
      #1;
      checks++;
      if ({req1_done, req0_done} !== {exp, ~exp}) begin
        errors++; $display("FAIL alt_done_%0d: got %b expected %b", k, {req1_done, req0_done}, {exp, ~exp});
      end
      cyc();
      malu_idone = 1'b0;
      if (k == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      #1;
      checks++;
      if ({req1_gnt, req0_gnt} !== 2'b00) begin
        errors++; $display("FAIL alt_bubble_%0d: got %b expected 00", k, {req1_gnt, req0_gnt});
      end
    end
  endtask

  task automatic test_wait();
    req0_valid = 1'b1; req0_rs1 = 32'hA5A5_0001; req1_rs1 = 32'h5A5A_0002;
    cyc(); #1;
    checks++;
    if (req0_gnt !== 1'b1) begin errors++; $display("FAIL wait_gnt0: got %b expected 1", req0_gnt); end
    req1_valid = 1'b1; malu_rd_ben = 4'hF; malu_rd_wdata = 32'h1234_5678;
    #1;
    checks++;
    if ({req1_gnt, req1_rd_ben, req1_rd_wdata} !== 37'd0) begin
      errors++; $display("FAIL wait_nonowner: got %b %h %h expected 0 0 0", req1_gnt, req1_rd_ben, req1_rd_wdata);
    end
    checks++;
    if ({req0_rd_wdata, malu_rs1} !== {32'h1234_5678, 32'hA5A5_0001}) begin
      errors++; $display("FAIL wait_owner_path: got %h %h expected 12345678 a5a50001", req0_rd_wdata, malu_rs1);
    end
    cyc();
    cyc();
    malu_idone = 1'b1; req0_valid = 1'b0;
    #1;
    checks++;
    if ({req0_done, req1_done, req1_gnt} !== 3'b100) begin
      errors++; $display("FAIL wait_done0: got %b expected 100", {req0_done, req1_done, req1_gnt});
    end
    cyc();
    malu_idone = 1'b0; malu_rd_ben = 4'd0; malu_rd_wdata = 32'd0;
    cyc(); #1;
    checks++;
    if ({req1_gnt, req0_gnt, malu_rs1} !== {2'b10, 32'h5A5A_0002}) begin
      errors++; $display("FAIL wait_gnt1: got %b %h expected 10 5a5a0002", {req1_gnt, req0_gnt}, malu_rs1);
    end
    malu_idone = 1'b1; req1_valid = 1'b0;
    #1;
    checks++;
    if (req1_done !== 1'b1) begin errors++; $display("FAIL wait_done1: got %b expected 1", req1_done); end
    cyc();
    malu_idone = 1'b0;
  endtask

  task automatic test_wdog();
    req0_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      checks++;
      if ({req0_gnt, err_wdog} !== 2'b10) begin
        errors++; $display("FAIL wdog_busy_%0d: got %b expected 10", i, {req0_gnt, err_wdog});
      end
    end
    cyc(); #1;
    checks++;
    if ({err_wdog, req0_gnt, err_proto} !== 3'b100) begin
      errors++; $display("FAIL wdog_expire: got %b expected 100", {err_wdog, req0_gnt, err_proto});
    end
    cyc(); #1;
    checks++;
    if (req0_gnt !== 1'b1) begin errors++; $display("FAIL wdog_regrant: got %b expected 1", req0_gnt); end
    malu_idone = 1'b1; req0_valid = 1'b0;
    cyc();
    malu_idone = 1'b0;
    #1;
    checks++;
    if (err_wdog !== 1'b1) begin errors++; $display("FAIL wdog_sticky: got %b expected 1", err_wdog); end
  endtask

  task automatic test_proto();
    // prio now names req1 (last completion was req0)
    req1_valid = 1'b1;
    cyc(); #1;
    checks++;
    if (req1_gnt !== 1'b1) begin errors++; $display("FAIL proto_gnt1: got %b expected 1", req1_gnt); end
    cyc();
    req1_valid = 1'b0;
    #1;
    checks++;
    if (malu_ivalid !== 1'b0) begin errors++; $display("FAIL proto_ivalid_drop: got %b expected 0", malu_ivalid); end
    cyc(); #1;
    checks++;
    if ({err_proto, req1_gnt, malu_ivalid} !== 3'b100) begin
      errors++; $display("FAIL proto_flag: got %b expected 100", {err_proto, req1_gnt, malu_ivalid});
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    cyc(); #1;
    checks++;
    if ({req1_gnt, req0_gnt} !== 2'b10) begin
      errors++; $display("FAIL proto_prio_kept: got %b expected 10", {req1_gnt, req0_gnt});
    end
  endtask

  task automatic test_reset_busy();
    g_resetn = 1'b0; malu_rd_ben = 4'hF; malu_rd_wdata = 32'hDEAD_BEEF; malu_rdm_in_rs = 1'b1;
    cyc(); #1;
    checks++;
    if ({req0_gnt, req1_gnt, malu_ivalid, err_wdog, err_proto, req1_rd_ben, req1_rd_wdata, req1_rdm_in_rs}
        !== 42'd0) begin
      errors++; $display("FAIL rst_busy_outputs: got %b %b %b %b %b %h %h %b expected all 0",
                         req0_gnt, req1_gnt, malu_ivalid, err_wdog, err_proto,
                         req1_rd_ben, req1_rd_wdata, req1_rdm_in_rs);
    end
    checks++;
    if (malu_rs1 !== 32'd0) begin errors++; $display("FAIL rst_busy_malu: got %h expected 0", malu_rs1); end
    g_resetn = 1'b1; malu_rd_ben = 4'd0; malu_rd_wdata = 32'd0; malu_rdm_in_rs = 1'b0;
    cyc(); #1;
    checks++;
    if ({req1_gnt, req0_gnt} !== 2'b01) begin
      errors++; $display("FAIL rst_busy_prio: got %b expected 01", {req1_gnt, req0_gnt});
    end
    malu_idone = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
    malu_idone = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wait();
    test_wdog();
    test_proto();
    test_reset_busy();
    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
